mant_align_rshift: RTL and testbench

- Iterative right-shift alignment unit for the floating-point adder datapath.
- Takes the 25-bit mantissa of the smaller-exponent operand and the exponent difference, and shifts it right to align it with the larger operand.
- Produces guard, round and sticky bits for rounding.
- It is the opposite direction of the leading-one/left-shift normalization stage. Shifts are done STEP bits per cycle, with a valid/ready handshake on both sides.

---
 rtl/mant_align_rshift.sv | 116 +++++++++++
 tb/tb_mant_align_rshift.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mant_align_rshift.sv
// Iterative right-shift alignment for the FP adder: shifts the smaller operand's mantissa
// right by the exponent difference, STEP bits per cycle, and collects guard/round/sticky.
module mant_align_rshift #(
  parameter int unsigned W    = 25,
  parameter int unsigned STEP = 4,
  parameter int unsigned SHW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   mant_in,
  input  logic [SHW-1:0] shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   mant_out,
  output logic           guard,
  output logic           round,
  output logic           sticky
);

  localparam int unsigned      EW      = W + 2;
  localparam logic [SHW-1:0]   StepAmt = SHW'(STEP);
  localparam logic [31:0]      SatLim  = 32'(W + 2);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic           g_q, g_d;
  logic           r_q, r_d;
  logic           s_q, s_d;
  logic [SHW-1:0] rem_q, rem_d;

  logic [SHW-1:0] k;
  logic [EW-1:0]  ext;
  logic [EW-1:0]  ext_sh;
  logic [EW-1:0]  drop_mask;

  // Per-cycle step: the low k bits of {m,g,r} fall into sticky.
  always_comb begin
    k         = (rem_q < StepAmt) ? rem_q : StepAmt;
    ext       = {m_q, g_q, r_q};
    ext_sh    = ext >> k;
    drop_mask = (EW'(1) << k) - EW'(1);
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    g_d     = g_q;
    r_d     = r_q;
    s_d     = s_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          m_d   = mant_in;
          g_d   = 1'b0;
          r_d   = 1'b0;
          s_d   = 1'b0;
          rem_d = shamt;
          if (shamt == '0) begin
            state_d = StDone;
          end else if (32'(shamt) >= SatLim) begin
            // Everything, including the MSB, passes below round.
            m_d     = '0;
            s_d     = |mant_in;
            rem_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        {m_d, g_d, r_d} = ext_sh;
        s_d             = s_q | (|(ext & drop_mask));
        rem_d           = rem_q - k;
        if (rem_q == k) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      m_q     <= '0;
      g_q     <= 1'b0;
      r_q     <= 1'b0;
      s_q     <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      g_q     <= g_d;
      r_q     <= r_d;
      s_q     <= s_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle) & ~rst;
    out_valid = (state_q == StDone);
    mant_out  = out_valid ? m_q : '0;
    guard     = out_valid & g_q;
    round     = out_valid & r_q;
    sticky    = out_valid & s_q;
  end

endmodule

// File: tb/tb_mant_align_rshift.sv
// Randomized and directed bench for mant_align_rshift against a bit-position reference model.
module tb_mant_align_rshift;

  localparam int W    = 25;
  localparam int STEP = 4;
  localparam int SHW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mant_in;
  logic [SHW-1:0] shamt;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   mant_out;
  logic           guard;
  logic           round;
  logic           sticky;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mant_align_rshift #(.W(W), .STEP(STEP), .SHW(SHW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mant_in  (mant_in),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mant_out (mant_out),
    .guard    (guard),
    .round    (round),
    .sticky   (sticky)
  );

  // Each set input bit i lands at position i-sh: >=0 in mant, -1 guard, -2 round, below sticky.
  function automatic logic [W+2:0] ref_align(input logic [W-1:0] mant, input int sh);
    logic [W-1:0] m;
    logic g, r, s;
    int pos;
    m = '0; g = 1'b0; r = 1'b0; s = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (mant[i]) begin
        pos = i - sh;
        if (pos >= 0) m[pos] = 1'b1;
        else if (pos == -1) g = 1'b1;
        else if (pos == -2) r = 1'b1;
        else s = 1'b1;
      end
    end
    return {m, g, r, s};
  endfunction

  function automatic int ref_lat(input int sh);
    if (sh == 0 || sh >= W + 2) return 1;
    return (sh + STEP - 1) / STEP + 1;
  endfunction

  // Drives one operand, scrambles inputs after acceptance, measures edges to out_valid.
  task automatic do_op(input logic [W-1:0] mant, input int sh,
                       output logic [W+2:0] obs, output int lat);
    in_valid = 1'b1;
    mant_in  = mant;
    shamt    = SHW'(sh);
    @(posedge clk); #1;
    in_valid = 1'b0;
    mant_in  = W'($urandom);
    shamt    = SHW'($urandom);
    lat      = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    obs = {mant_out, guard, round, sticky};
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    mant_in = W'($urandom); shamt = SHW'(3);
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, mant_out, guard, round, sticky} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_valid, mant_out, guard, round, sticky});
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] tm [10] = '{25'h1000000, 25'h1FFFFFF, 25'h0000001, 25'h0000001, 25'h0000001,
                              25'h1000000, 25'h1000000, 25'h0000003, 25'h0000000, 25'h155AAAA};
    int           ts [10] = '{1, 10, 26, 25, 27, 26, 25, 200, 200, 0};
    logic [W+2:0] obs, exp_v;
    int           lat;
    for (int i = 0; i < 10; i++) begin
      do_op(tm[i], ts[i], obs, lat);
      exp_v = ref_align(tm[i], ts[i]);
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL directed_%0d result: mant=%h sh=%0d got %h expected %h",
                 i, tm[i], ts[i], obs, exp_v);
      end
      n_vec++;
      if (lat !== ref_lat(ts[i])) begin
        n_err++;
        $display("FAIL directed_%0d latency: sh=%0d got %0d expected %0d",
                 i, ts[i], lat, ref_lat(ts[i]));
      end
      if (i == 0) begin
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL directed_0 one_cycle_valid: got valid=%b ready=%b expected 0/1",
                   out_valid, in_ready);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m;
    int           sh, lat;
    logic [W+2:0] obs, exp_v;
    for (int i = 0; i < 80; i++) begin
      m  = W'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 30);
      do_op(m, sh, obs, lat);
      exp_v = ref_align(m, sh);
      n_vec++;
      if (obs !== exp_v || lat !== ref_lat(sh)) begin
        n_err++;
        $display("FAIL random_%0d: mant=%h sh=%0d got %h lat %0d expected %h lat %0d",
                 i, m, sh, obs, lat, exp_v, ref_lat(sh));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] m0, m1;
    logic [W+2:0] obs, exp_v;
    int           lat;
    m0 = 25'h0ABCDEF;
    m1 = W'($urandom);
    out_ready = 1'b0;
    do_op(m0, 9, obs, lat);
    exp_v = ref_align(m0, 9);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL bp_result: got %h expected %h", obs, exp_v);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; mant_in = W'($urandom); shamt = SHW'($urandom_range(0, 30));
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {mant_out, guard, round, sticky} !== exp_v) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got valid=%b ready=%b res=%h expected 1/0/%h",
                 c, out_valid, in_ready, {mant_out, guard, round, sticky}, exp_v);
      end
    end
    mant_in = m1; shamt = SHW'(7); out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_v = ref_align(m1, 7);
    n_vec++;
    if ({mant_out, guard, round, sticky} !== exp_v || lat !== ref_lat(7)) begin
      n_err++;
      $display("FAIL bp_next_op: got %h lat %0d expected %h lat %0d",
               {mant_out, guard, round, sticky}, lat, exp_v, ref_lat(7));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    logic [W-1:0] m;
    logic [W+2:0] obs, exp_v;
    int           lat;
    m = 25'h1F0F0F3;
    in_valid = 1'b1; mant_in = m; shamt = SHW'(20);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_during: got ready=%b valid=%b expected 0/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, mant_out, guard, round, sticky} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_after: got %h ready=%b expected 0 ready=1",
               {out_valid, mant_out, guard, round, sticky}, in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_mid_no_stale_%0d: got valid=%b expected 0", c, out_valid);
      end
    end
    m = 25'h0123457;
    do_op(m, 13, obs, lat);
    exp_v = ref_align(m, 13);
    n_vec++;
    if (obs !== exp_v || lat !== ref_lat(13)) begin
      n_err++;
      $display("FAIL rst_mid_follow: got %h lat %0d expected %h lat %0d",
               obs, lat, exp_v, ref_lat(13));
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mant_in = '0; shamt = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
